sprite_rom_arbiter: RTL

Shares one single-port on-chip sprite ROM between the pixel-pipeline requesters: player car lookup, NPC car lookup, and the collision checker in game state. It runs on the 50 MHz system clock, giving two arbitration slots per 25 MHz pixel. Round-robin arbitration with a request/grant handshake feeds a tagged read pipeline, and data comes back to the owning requester. A per-frame flush realigns the arbitration pointer at the start of each VGA frame.

---
 rtl/sprite_rom_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between pixel-pipeline
// requesters, with a tagged read pipeline that routes data to the owner.
//
// Ports:
//   Clk, Reset_n        system clock, async active-low reset
//   frame_flush         one-cycle pulse, restarts arbitration at requester 0
//   req, req_addr       per-requester request and address (held until gnt)
//   gnt                 combinational one-hot grant
//   rom_addr, rom_rd    registered ROM address and read strobe
//   rom_data            ROM read data, valid ROM_LATENCY cycles after rom_addr
//   rvalid, rdata       per-requester return pulse and held return data
//
// Option macro SPRITE_ARB_PRIO0_EN: requester 0 wins whenever it asks and
// does not move the round-robin pointer.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_flush,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rd,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ*DATA_W-1:0] rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = ROM_LATENCY + 1;

    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          base;
    logic [PTR_W-1:0]          win_idx;
    logic                      win_vld;
    logic [ADDR_W-1:0]         win_addr;
    int                        cand;

    logic [ADDR_W-1:0]         rom_addr_q;
    logic                      rom_rd_q;
    logic [DEPTH-1:0]          tag_vld_q;
    logic [PTR_W-1:0]          tag_idx_q [DEPTH];
    logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;
    logic [NUM_REQ*DATA_W-1:0] rdata_q, rdata_d;

    // Arbitration: scan from base upward with explicit wrap; first hit wins.
    always_comb begin
        base     = frame_flush ? '0 : rr_ptr_q;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        cand     = 0;
        gnt      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(base) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`ifdef SPRITE_ARB_PRIO0_EN
            if (!win_vld && cand != 0 && req[cand]) begin
`else
            if (!win_vld && req[cand]) begin
`endif
                win_vld  = 1'b1;
                win_idx  = PTR_W'(cand);
                win_addr = req_addr[cand*ADDR_W +: ADDR_W];
            end
        end
`ifdef SPRITE_ARB_PRIO0_EN
        if (req[0]) begin
            win_vld  = 1'b1;
            win_idx  = '0;
            win_addr = req_addr[0 +: ADDR_W];
        end
`endif
        if (win_vld) gnt[win_idx] = 1'b1;

        // A flush with no grant still leaves the pointer realigned at 0.
        rr_ptr_d = base;
`ifdef SPRITE_ARB_PRIO0_EN
        if (win_vld && win_idx != '0) begin
`else
        if (win_vld) begin
`endif
            if (win_idx == PTR_W'(NUM_REQ - 1)) rr_ptr_d = '0;
            else                                rr_ptr_d = win_idx + 1'b1;
        end
    end

    // Return stage: the oldest tag names the owner of the sampled rom_data.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_vld_q[DEPTH-1] && tag_idx_q[DEPTH-1] == PTR_W'(i)) begin
                rvalid_d[i]                   = 1'b1;
                rdata_d[i*DATA_W +: DATA_W]   = rom_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q   <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            tag_vld_q  <= '0;
            for (int k = 0; k < DEPTH; k++) tag_idx_q[k] <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_rd_q   <= win_vld;
            if (win_vld) rom_addr_q <= win_addr;
            tag_vld_q  <= {tag_vld_q[DEPTH-2:0], win_vld};
            tag_idx_q[0] <= win_idx;
            for (int k = 1; k < DEPTH; k++) tag_idx_q[k] <= tag_idx_q[k-1];
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_rd   = rom_rd_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule
